// File: rtl/fifo_rd_skid_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid_pkg
// Shared definitions for the FIFO read-side skid buffer:
//   level_e     - buffer occupancy encoding (LVL_EMPTY / LVL_ONE / LVL_TWO),
//                 also used directly as the skid buffer state and o_level value
//   D_SIZE_DEF  - default data word width
//   CNT_W_DEF   - default popped-word counter width
// -----------------------------------------------------------------------------
package fifo_rd_skid_pkg;

  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_TWO   = 2'd2
  } level_e;

  localparam int D_SIZE_DEF = 16;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/fifo_rd_skid_skid_reg2.sv
// -----------------------------------------------------------------------------
// skid_reg2
// Two-entry register FIFO (head/tail) whose state is the occupancy level.
// The head word is always a register so the downstream data path never sees
// a combinational path from the write data.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset (clears level and storage)
//   flush      - synchronous discard of all stored words
//   push       - write push_data this edge (caller guarantees level < 2)
//   push_data  - word to store
//   pop        - consumer took the head word this edge (caller guarantees level > 0)
//   level      - number of stored words, 0..2
//   head_data  - oldest stored word
// -----------------------------------------------------------------------------
module skid_reg2
  import fifo_rd_skid_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [D_SIZE-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        level,
  output logic [D_SIZE-1:0] head_data
);

  level_e            state_q, state_d;
  logic [D_SIZE-1:0] head_q, head_d;
  logic [D_SIZE-1:0] tail_q, tail_d;

  // State and storage registers; reset clears the stored words as well
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LVL_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next level and storage update. In ONE a simultaneous push and pop
  // replaces the head directly so the level holds at ONE and throughput
  // stays at one word per cycle. In TWO a pop promotes the tail to head.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = LVL_EMPTY;
    end else begin
      case (state_q)
        LVL_EMPTY: begin
          if (push) begin
            head_d  = push_data;
            state_d = LVL_ONE;
          end
        end
        LVL_ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_d  = push_data;
              state_d = LVL_TWO;
            end
            2'b11: begin
              head_d = push_data;
            end
            2'b01: begin
              state_d = LVL_EMPTY;
            end
            default: begin
            end
          endcase
        end
        LVL_TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = LVL_ONE;
          end
        end
        default: begin
          state_d = LVL_EMPTY;
        end
      endcase
    end
  end

  assign level     = state_q;
  assign head_data = head_q;

endmodule

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Read-side adapter between a first-word-fall-through async FIFO and a
// valid/ready stream. Pops the FIFO into a 2-entry skid buffer whenever there
// is room, independent of downstream ready, so the registered output sustains
// one word per cycle.
// Ports:
//   i_clk          - FIFO read-domain clock
//   i_rst          - synchronous active-high reset
//   i_fifo_empty   - upstream FIFO empty flag
//   i_fifo_rd_data - upstream FIFO head word (valid when not empty)
//   o_fifo_rd_en   - pop strobe to the upstream FIFO
//   i_flush        - synchronous discard of buffered words
//   o_valid        - stream valid
//   o_data         - stream data (registered)
//   i_ready        - stream ready
//   o_level        - buffered word count, 0..2
//   o_pop_cnt      - words popped since reset, wrapping
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_rd_skid_pkg::*;
#(
  parameter int D_SIZE = D_SIZE_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fifo_empty,
  input  logic [D_SIZE-1:0] i_fifo_rd_data,
  output logic              o_fifo_rd_en,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [D_SIZE-1:0] o_data,
  input  logic              i_ready,
  output logic [1:0]        o_level,
  output logic [CNT_W-1:0]  o_pop_cnt
);

  logic             pop;
  logic             transfer;
  logic [1:0]       level;
  logic [CNT_W-1:0] pop_cnt_q;

  // Pop only when there is room; reset and flush block the pop so no FIFO
  // word is consumed and then thrown away.
  assign pop = !i_fifo_empty && (level != LVL_TWO) && !i_flush && !i_rst;

  assign o_valid  = (level != LVL_EMPTY);
  assign transfer = o_valid && i_ready;

  skid_reg2 #(
    .D_SIZE (D_SIZE)
  ) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (i_flush),
    .push      (pop),
    .push_data (i_fifo_rd_data),
    .pop       (transfer),
    .level     (level),
    .head_data (o_data)
  );

  // Popped-word counter, wraps naturally at 2^CNT_W
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pop_cnt_q <= '0;
    end else if (pop) begin
      pop_cnt_q <= pop_cnt_q + CNT_W'(1);
    end
  end

  assign o_fifo_rd_en = pop;
  assign o_level      = level;
  assign o_pop_cnt    = pop_cnt_q;

endmodule
